// File: rtl/stage_sequencer.sv
// Multi-cycle stage sequencer for the ARM datapath: issues one-cycle stage strobes,
// inserts MEMORY/WRITEBACK only when needed, and traps memory timeouts in a sticky ERROR.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | halted at an instruction boundary, waiting for run
// FETCH     | if_go: load instruction-fetch register
// REGFETCH  | rf_go: load register-fetch register, latch decode flags
// EXECUTE   | ex_go: load execute register, latch cond_pass, pick path
// MEMORY    | mem_req held; dm_go when mem_ack; bounded by MEM_TIMEOUT
// WRITEBACK | reg_we: register-file write
// PCUPDATE  | pc_go (+branch_taken), retire instruction
// ERROR     | err sticky, all strobes low, left only by nreset
module stage_sequencer #(
  parameter int          MEM_TIMEOUT = 15,
  parameter logic [15:0] COUNT_INIT  = 16'h0000
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        run,
  input  logic        is_mem,
  input  logic        is_load,
  input  logic        is_branch,
  input  logic        cond_pass,
  input  logic        mem_ack,
  output logic        if_go,
  output logic        rf_go,
  output logic        ex_go,
  output logic        dm_go,
  output logic        pc_go,
  output logic        mem_req,
  output logic        reg_we,
  output logic        branch_taken,
  output logic [2:0]  state,
  output logic [15:0] instr_count,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_REGFETCH  = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMORY    = 3'd4,
    S_WRITEBACK = 3'd5,
    S_PCUPDATE  = 3'd6,
    S_ERROR     = 3'd7
  } st_t;

  // Counter value seen in the last allowed no-ack MEMORY cycle.
  localparam logic [7:0] LP_WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  st_t         r_state;
  logic        r_mem_l;
  logic        r_load_l;
  logic        r_br_l;
  logic        r_cp_l;
  logic [7:0]  r_wait_cnt;
  logic [15:0] r_instr_count;
  logic        r_if_go;
  logic        r_rf_go;
  logic        r_ex_go;
  logic        r_pc_go;
  logic        r_mem_req;
  logic        r_reg_we;
  logic        r_branch_taken;
  logic        r_err;

  st_t         w_next;
  logic        w_bt_next;

  always_comb begin
    w_next    = r_state;
    w_bt_next = r_br_l & r_cp_l;
    case (r_state)
      S_IDLE:      w_next = run ? S_FETCH : S_IDLE;
      S_FETCH:     w_next = S_REGFETCH;
      S_REGFETCH:  w_next = S_EXECUTE;
      S_EXECUTE: begin
        // cp_l is still being captured, so use the live condition result
        w_bt_next = r_br_l & cond_pass;
        if (!cond_pass)   w_next = S_PCUPDATE;
        else if (r_mem_l) w_next = S_MEMORY;
        else if (r_br_l)  w_next = S_PCUPDATE;
        else              w_next = S_WRITEBACK;
      end
      S_MEMORY: begin
        if (mem_ack)                         w_next = r_load_l ? S_WRITEBACK : S_PCUPDATE;
        else if (r_wait_cnt == LP_WAIT_LAST) w_next = S_ERROR;
        else                                 w_next = S_MEMORY;
      end
      S_WRITEBACK: w_next = S_PCUPDATE;
      S_PCUPDATE:  w_next = run ? S_FETCH : S_IDLE;
      S_ERROR:     w_next = S_ERROR;
      default:     w_next = S_IDLE;
    endcase
  end

  // Outputs are registered from the next-state decode so they are valid for the whole state.
  always_ff @(posedge clk or posedge nreset) begin
    if (nreset) begin
      r_state        <= S_IDLE;
      r_mem_l        <= 1'b0;
      r_load_l       <= 1'b0;
      r_br_l         <= 1'b0;
      r_cp_l         <= 1'b0;
      r_wait_cnt     <= 8'd0;
      r_instr_count  <= COUNT_INIT;
      r_if_go        <= 1'b0;
      r_rf_go        <= 1'b0;
      r_ex_go        <= 1'b0;
      r_pc_go        <= 1'b0;
      r_mem_req      <= 1'b0;
      r_reg_we       <= 1'b0;
      r_branch_taken <= 1'b0;
      r_err          <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_REGFETCH) begin
        r_mem_l  <= is_mem;
        r_load_l <= is_load;
        r_br_l   <= is_branch;
      end
      if (r_state == S_EXECUTE) r_cp_l <= cond_pass;
      if (w_next == S_MEMORY && r_state != S_MEMORY) r_wait_cnt <= 8'd0;
      else if (r_state == S_MEMORY && !mem_ack)      r_wait_cnt <= r_wait_cnt + 8'd1;
      if (r_state == S_PCUPDATE) r_instr_count <= r_instr_count + 16'd1;
      r_if_go        <= (w_next == S_FETCH);
      r_rf_go        <= (w_next == S_REGFETCH);
      r_ex_go        <= (w_next == S_EXECUTE);
      r_pc_go        <= (w_next == S_PCUPDATE);
      r_mem_req      <= (w_next == S_MEMORY);
      r_reg_we       <= (w_next == S_WRITEBACK);
      r_branch_taken <= (w_next == S_PCUPDATE) & w_bt_next;
      r_err          <= (w_next == S_ERROR);
    end
  end

  assign if_go        = r_if_go;
  assign rf_go        = r_rf_go;
  assign ex_go        = r_ex_go;
  assign dm_go        = (r_state == S_MEMORY) & mem_ack;
  assign pc_go        = r_pc_go;
  assign mem_req      = r_mem_req;
  assign reg_we       = r_reg_we;
  assign branch_taken = r_branch_taken;
  assign state        = r_state;
  assign instr_count  = r_instr_count;
  assign err          = r_err;

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed bench for stage_sequencer: main instance with MEM_TIMEOUT=4, plus a second
// instance preloaded to 0xFFFE retirements to exercise counter wrap.
module tb_stage_sequencer;

  logic clk = 1'b0;
  logic nreset, run, is_mem, is_load, is_branch, cond_pass, mem_ack;

  logic        if_go, rf_go, ex_go, dm_go, pc_go, mem_req, reg_we, branch_taken, err;
  logic [2:0]  state;
  logic [15:0] instr_count;

  logic        w_if_go, w_rf_go, w_ex_go, w_dm_go, w_pc_go, w_mem_req, w_reg_we, w_bt, w_err;
  logic [2:0]  w_state;
  logic [15:0] w_count;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [8:0] IF = 9'b100000000;
  localparam logic [8:0] RF = 9'b010000000;
  localparam logic [8:0] EX = 9'b001000000;
  localparam logic [8:0] DM = 9'b000100000;
  localparam logic [8:0] PC = 9'b000010000;
  localparam logic [8:0] MR = 9'b000001000;
  localparam logic [8:0] WE = 9'b000000100;
  localparam logic [8:0] BT = 9'b000000010;
  localparam logic [8:0] ER = 9'b000000001;
  localparam logic [8:0] NO = 9'b000000000;

  always #5 clk = ~clk;

  stage_sequencer #(.MEM_TIMEOUT(4)) u_dut (
    .clk(clk), .nreset(nreset), .run(run), .is_mem(is_mem), .is_load(is_load),
    .is_branch(is_branch), .cond_pass(cond_pass), .mem_ack(mem_ack),
    .if_go(if_go), .rf_go(rf_go), .ex_go(ex_go), .dm_go(dm_go), .pc_go(pc_go),
    .mem_req(mem_req), .reg_we(reg_we), .branch_taken(branch_taken),
    .state(state), .instr_count(instr_count), .err(err)
  );

  stage_sequencer #(.COUNT_INIT(16'hFFFE)) u_wrap (
    .clk(clk), .nreset(nreset), .run(run), .is_mem(is_mem), .is_load(is_load),
    .is_branch(is_branch), .cond_pass(cond_pass), .mem_ack(mem_ack),
    .if_go(w_if_go), .rf_go(w_rf_go), .ex_go(w_ex_go), .dm_go(w_dm_go), .pc_go(w_pc_go),
    .mem_req(w_mem_req), .reg_we(w_reg_we), .branch_taken(w_bt),
    .state(w_state), .instr_count(w_count), .err(w_err)
  );

  logic [8:0] vec;
  assign vec = {if_go, rf_go, ex_go, dm_go, pc_go, mem_req, reg_we, branch_taken, err};

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_cyc(input string tag, input logic [2:0] st, input logic [8:0] v);
    chk({tag, "_state"}, {13'd0, state}, {13'd0, st});
    chk({tag, "_outs"}, {7'd0, vec}, {7'd0, v});
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Starts with FETCH visible; walks an ALU op back to the next FETCH.
  task automatic alu_op(input string tag);
    tick; expect_cyc({tag, "_rf"}, 3'd2, RF);
    tick; expect_cyc({tag, "_ex"}, 3'd3, EX);
    tick; expect_cyc({tag, "_wb"}, 3'd5, WE);
    tick; expect_cyc({tag, "_pc"}, 3'd6, PC);
    tick; expect_cyc({tag, "_f"},  3'd1, IF);
  endtask

  initial begin
    nreset = 1'b1; run = 1'b0; is_mem = 1'b0; is_load = 1'b0;
    is_branch = 1'b0; cond_pass = 1'b0; mem_ack = 1'b0;
    tick; tick;
    expect_cyc("reset", 3'd0, NO);
    chk("reset_count", instr_count, 16'h0000);
    chk("reset_wrap_count", w_count, 16'hFFFE);
    nreset = 1'b0;
    tick; expect_cyc("idle_hold", 3'd0, NO);

    // ALU op, then two more to drive the preloaded counter through the wrap
    run = 1'b1; cond_pass = 1'b1;
    tick; expect_cyc("alu1_f", 3'd1, IF);
    alu_op("alu1");
    chk("alu1_count", instr_count, 16'd1);
    chk("wrap_ffff", w_count, 16'hFFFF);
    alu_op("alu2");
    chk("wrap_0000", w_count, 16'h0000);
    alu_op("alu3");
    chk("wrap_0001", w_count, 16'h0001);
    chk("alu3_count", instr_count, 16'd3);

    is_branch = 1'b1;
    tick; expect_cyc("br_rf", 3'd2, RF);
    tick; expect_cyc("br_ex", 3'd3, EX);
    tick; expect_cyc("br_pc", 3'd6, PC | BT);
    tick; expect_cyc("br_f",  3'd1, IF);

    cond_pass = 1'b0;
    tick; expect_cyc("bnt_rf", 3'd2, RF);
    tick; expect_cyc("bnt_ex", 3'd3, EX);
    tick; expect_cyc("bnt_pc", 3'd6, PC);
    tick; expect_cyc("bnt_f",  3'd1, IF);
    chk("bnt_count", instr_count, 16'd5);

    // Load: three no-ack MEMORY cycles, ack on the fourth (the last one allowed)
    is_branch = 1'b0; is_mem = 1'b1; is_load = 1'b1; cond_pass = 1'b1;
    tick; expect_cyc("ld_rf", 3'd2, RF);
    tick; expect_cyc("ld_ex", 3'd3, EX);
    tick; expect_cyc("ld_m1", 3'd4, MR);
    tick; expect_cyc("ld_m2", 3'd4, MR);
    tick; expect_cyc("ld_m3", 3'd4, MR);
    tick; mem_ack = 1'b1; #1;
    expect_cyc("ld_m4", 3'd4, MR | DM);
    tick; mem_ack = 1'b0;
    expect_cyc("ld_wb", 3'd5, WE);
    tick; expect_cyc("ld_pc", 3'd6, PC);
    tick; expect_cyc("ld_f",  3'd1, IF);

    // Store, ack held high throughout (ignored before MEMORY)
    is_load = 1'b0; mem_ack = 1'b1;
    tick; expect_cyc("st_rf", 3'd2, RF);
    tick; expect_cyc("st_ex", 3'd3, EX);
    tick; expect_cyc("st_m1", 3'd4, MR | DM);
    tick; expect_cyc("st_pc", 3'd6, PC);
    tick; expect_cyc("st_f",  3'd1, IF);
    chk("st_count", instr_count, 16'd7);

    // run dropped in EXECUTE: instruction completes and parks in IDLE
    mem_ack = 1'b0; is_mem = 1'b0;
    tick; expect_cyc("rd_rf", 3'd2, RF);
    tick; expect_cyc("rd_ex", 3'd3, EX);
    run = 1'b0;
    tick; expect_cyc("rd_wb", 3'd5, WE);
    tick; expect_cyc("rd_pc", 3'd6, PC);
    tick; expect_cyc("rd_idle", 3'd0, NO);
    tick; expect_cyc("rd_idle2", 3'd0, NO);
    chk("rd_count", instr_count, 16'd8);
    run = 1'b1;
    tick; expect_cyc("rd_resume", 3'd1, IF);

    // async reset in the middle of a MEMORY cycle
    is_mem = 1'b1;
    tick; expect_cyc("ar_rf", 3'd2, RF);
    tick; expect_cyc("ar_ex", 3'd3, EX);
    tick; expect_cyc("ar_m1", 3'd4, MR);
    #2; nreset = 1'b1; #1;
    expect_cyc("ar_async", 3'd0, NO);
    chk("ar_count", instr_count, 16'd0);
    tick; nreset = 1'b0;

    // Timeout: no ack for four MEMORY cycles
    is_load = 1'b1;
    tick; expect_cyc("to_f",  3'd1, IF);
    tick; expect_cyc("to_rf", 3'd2, RF);
    tick; expect_cyc("to_ex", 3'd3, EX);
    for (int i = 0; i < 4; i++) begin
      tick; expect_cyc($sformatf("to_m%0d", i + 1), 3'd4, MR);
    end
    tick; expect_cyc("to_err", 3'd7, ER);
    tick; expect_cyc("to_err_hold1", 3'd7, ER);
    tick; expect_cyc("to_err_hold2", 3'd7, ER);
    nreset = 1'b1; #1;
    expect_cyc("to_reset", 3'd0, NO);
    tick;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
